// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers. Executes MULT, MULTU, DIV, DIVU (one shift-add or
//               restoring-subtract step per cycle on operand magnitudes) and
//               MTHI/MTLO. Holds busy while an operation is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int         c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FIX   = 2'd2;
    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;      // all WIDTH steps done; next edge writes HI/LO
    logic               r_is_div;
    logic               r_neg_q;     // negate product / quotient
    logic               r_neg_r;     // negate remainder (sign of dividend)
    logic               r_dz;        // divide by zero
    logic [WIDTH-1:0]   r_srca;      // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   r_b;         // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_acc_hi;    // partial product high / partial remainder
    logic [WIDTH-1:0]   r_acc_lo;    // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_accept_md;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_finish;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_t;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_idle      = (r_state == c_S_IDLE);
    assign w_accept_md = w_idle && start && !op[2];
    assign w_mthi      = w_idle && start && (op == c_OP_MTHI);
    assign w_mtlo      = w_idle && start && (op == c_OP_MTLO);
    assign w_finish    = (r_state == c_S_RUN) && r_last;

    // Signed ops (op[0]==0) run on magnitudes; signs are re-applied at the end.
    assign w_sa    = !op[0] && srca[WIDTH-1];
    assign w_sb    = !op[0] && srcb[WIDTH-1];
    assign w_mag_a = w_sa ? (-srca) : srca;
    assign w_mag_b = w_sb ? (-srcb) : srcb;

    // Multiply step: conditionally add multiplicand, then shift {acc_hi,acc_lo} right.
    assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring divide step: shift next dividend bit into the remainder, try subtract.
    assign w_t    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge   = (w_t >= {1'b0, r_b});
    assign w_diff = w_t[WIDTH-1:0] - r_b;

    // Final sign correction and special-case selection.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
    assign w_quo_fix  = r_neg_q ? (-r_acc_lo) : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? (-r_acc_hi) : r_acc_hi;

    // Result mux written into HI/LO on the finishing edge.
    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = r_srca;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quo_fix;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: RUN covers the WIDTH steps plus the finishing edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept_md) w_state_next = c_S_RUN;
            c_S_RUN:  if (r_last)      w_state_next = c_S_FIX;
            c_S_FIX:                   w_state_next = c_S_IDLE;
            default:                   w_state_next = c_S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_srca   <= '0;
            r_b      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_accept_md) begin
                r_cnt    <= c_CNT_W'(WIDTH - 1);
                r_last   <= 1'b0;
                r_is_div <= op[1];
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_dz     <= op[1] && (srcb == '0);
                r_srca   <= srca;
                r_b      <= w_mag_b;
                r_acc_hi <= '0;
                r_acc_lo <= w_mag_a;
            end else if (w_finish) begin
                r_last <= 1'b0;
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
            end else if (r_state == c_S_RUN) begin
                if (r_is_div) begin
                    r_acc_hi <= w_ge ? w_diff : w_t[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                end else begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                end
                if (r_cnt == '0) begin
                    r_last <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            if (w_mthi) r_hi <= srca;
            if (w_mtlo) r_lo <= srca;
        end
    end

    assign busy = (r_state == c_S_RUN);
    assign done = (r_state == c_S_FIX);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit: expected HI/LO pushed at
//               issue time from a 64-bit arithmetic reference, popped by an
//               independent monitor whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks;
    int           n_errors;
    logic [31:0]  m_hi;
    logic [31:0]  m_lo;
    logic [63:0]  exp_q[$];
    string        name_q[$];
    logic         prev_done;
    logic [63:0]  mon_e;
    string        mon_n;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done cycle pops one expected result.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (prev_done) begin
                chk("done_pulse_len", 64'd2, 64'd1);
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                chk({mon_n, "_hi"}, {32'd0, hi}, {32'd0, mon_e[63:32]});
                chk({mon_n, "_lo"}, {32'd0, lo}, {32'd0, mon_e[31:0]});
            end
        end
        prev_done = (reset === 1'b1) && (done === 1'b1);
    end

    // Issue one mul/div; optionally inject a start during RUN or in the done cycle.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string nm, input int inj_at, input bit start_in_fix);
        logic [63:0] r;
        int cnt;
        r = ref_md(o, a, b);
        exp_q.push_back(r);
        name_q.push_back(nm);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 10) begin
                chk({nm, "_hold_hi"}, {32'd0, hi}, {32'd0, m_hi});
                chk({nm, "_hold_lo"}, {32'd0, lo}, {32'd0, m_lo});
            end
            if (cnt == inj_at) begin
                start = 1'b1; op = 3'b011; srca = 32'd99; srcb = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, "_busy_len"}, 64'(cnt), 64'd33);
        m_hi = r[63:32];
        m_lo = r[31:0];
        if (start_in_fix) begin
            start = 1'b1; op = 3'b101; srca = 32'h1111_2222;
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_done_drop"}, {63'd0, done}, 64'd0);
        if (start_in_fix) begin
            chk({nm, "_fix_start_lo"}, {32'd0, lo}, {32'd0, m_lo});
            chk({nm, "_fix_start_busy"}, {63'd0, busy}, 64'd0);
        end
    endtask

    // MTHI/MTLO or reserved op in IDLE.
    task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string nm);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'b100) m_hi = a;
        if (o == 3'b101) m_lo = a;
        chk({nm, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({nm, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
        chk({nm, "_busy"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; prev_done = 1'b0;
        reset = 1'b0; start = 1'b0; op = 3'd0; srca = '0; srcb = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b1;

        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, 1'b0);
        run_md(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", 0, 1'b0);
        run_md(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 0, 1'b0);
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0, 1'b0);
        run_md(3'd3, 32'd7, 32'd2, "divu_7_2", 0, 1'b0);
        run_md(3'd2, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 0, 1'b0);
        run_md(3'd2, 32'h1234_5678, 32'd0, "div_by_zero", 0, 1'b0);
        run_md(3'd3, 32'hDEAD_BEEF, 32'd0, "divu_by_zero", 0, 1'b0);
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 0, 1'b0);
        run_mt(3'b100, 32'hA5A5_A5A5, "mthi");
        run_mt(3'b101, 32'h5A5A_0F0F, "mtlo");
        run_mt(3'b110, 32'h1234_0000, "noop110");
        run_mt(3'b111, 32'h0000_4321, "noop111");
        run_md(3'd0, 32'd12345, 32'hFFFF_FF00, "mult_inject", 5, 1'b0);
        run_md(3'd3, 32'd1000, 32'd7, "divu_fixstart", 0, 1'b1);

        // Abort a MULT in RUN cycle 10; outputs must clear before the next edge.
        @(negedge clk);
        start = 1'b1; op = 3'd0; srca = 32'h0001_0001; srcb = 32'h0003_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_flags", {62'd0, busy, done}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_md(3'd1, 32'd3, 32'd5, "multu_3x5", 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 8)
                run_md(3'($urandom_range(0, 3)), pick(), pick(), "rand_md", 0, 1'b0);
            else
                run_mt(3'($urandom_range(4, 5)), $urandom, "rand_mt");
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
